uart_byte_rx: RTL

Serial-to-byte UART receiver: 8N1 frames on `rs232_rx` are oversampled 16x, majority-voted and delivered as a parallel byte with a one-cycle `rx_done` strobe. It is the upstream ingest stage of the picture path: its bytes feed the pixel packer and SDRAM write side. It uses the same `baud_set` coding as the UART transmitter, so both directions are configured from one register.

---
 rtl/uart_byte_rx.sv | 78 +++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and 2-of-3 majority vote per bit.
module uart_byte_rx #(
  parameter int BAUD0_TC = 324
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t      state;
  logic        s1, s2, s3, v6, v7, start_edge, tick, vote, fin;
  logic [15:0] tc_sel, tc_r, div_cnt;
  logic [3:0]  samp_cnt, bit_cnt;
  logic [7:0]  shadow;
  assign start_edge = s3 & ~s2;
  assign tick       = state == RECV && div_cnt == tc_r;
  assign vote       = (v6 & v7) | (v6 & s2) | (v7 & s2);
  // A frame ends at the mid-stop vote or at a start bit that votes high
  assign fin        = tick && samp_cnt == 4'd8 && (bit_cnt == 4'd9 || (bit_cnt == 4'd0 && vote));
  assign uart_state = state == RECV;
  always_comb
    tc_sel = baud_set == 4'd0 ? 16'(BAUD0_TC) :
             baud_set == 4'd1 ? 16'd162 :
             baud_set == 4'd2 ? 16'd80 :
             baud_set == 4'd3 ? 16'd53 :
             baud_set == 4'd4 ? 16'd26 : 16'd324;
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b111;
      {v6, v7}     <= 2'b11;
      state        <= IDLE;
      tc_r         <= '0;
      div_cnt      <= '0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      shadow       <= '0;
      data_byte    <= '0;
      rx_done      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rs232_rx, s1, s2};
      rx_done      <= 1'b0;
      frame_err    <= 1'b0;
      if (state == IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
        bit_cnt  <= '0;
        if (start_edge) begin
          state <= RECV;
          tc_r  <= tc_sel;
        end
      end else if (fin) begin
        state    <= IDLE;
        div_cnt  <= '0;
        samp_cnt <= '0;
        bit_cnt  <= '0;
        if (bit_cnt == 4'd9) begin
          rx_done   <= vote;
          frame_err <= ~vote;
          if (vote) data_byte <= shadow;
        end
      end else if (tick) begin
        div_cnt  <= '0;
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt == 4'd15) bit_cnt <= bit_cnt + 4'd1;
        if (samp_cnt == 4'd6) v6 <= s2;
        if (samp_cnt == 4'd7) v7 <= s2;
        if (samp_cnt == 4'd8 && bit_cnt != 4'd0) shadow <= {vote, shadow[7:1]};
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
endmodule
